// File: rtl/ip_codma_crc_engine.sv
// CRC-32 (IEEE 802.3, reflected) engine for the CODMA read path.
// Folds one 32-bit word of a latched read-data buffer per clock. The running
// accumulator persists across jobs, so a chained start continues one CRC
// stream over several bursts.
module ip_codma_crc_engine #(
    parameter int MAX_WORDS = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   chain_i,
    input  logic [3:0]             word_count_i,
    input  logic [MAX_WORDS*32-1:0] data_i,
    output logic                   busy_o,
    output logic                   crc_done_o,
    output logic [31:0]            crc_o,
    output logic                   error_o
);

    localparam int          IW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [4:0]  MAX_CNT  = 5'(MAX_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_WORDS - 1);
    localparam logic [31:0] POLY     = 32'hEDB88320;
    localparam logic [31:0] SEED     = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    buffer_q [MAX_WORDS];
    logic [3:0]     count_q;
    logic [IW-1:0]  idx_q;
    logic [31:0]    acc_q;

    logic           count_ok;
    logic           last_word;
    logic           accept;
    logic           reject;
    logic           abort;

    // Reflected CRC-32 update over one word. XOR-ing the whole word in and
    // shifting 32 times consumes bytes [7:0] first, each LSB first.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc ^ data;
        for (int b = 0; b < 32; b++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign busy_o = (state_q == CALC) || (state_q == DONE);

    // Next-state decode; stop_i overrides everything, including start_i.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        abort     = 1'b0;
        count_ok  = (word_count_i != 4'd0) && ({1'b0, word_count_i} <= MAX_CNT);
        last_word = ({1'b0, count_q} == (5'(idx_q) + 5'd1));

        if (stop_i) begin
            state_d = IDLE;
            abort   = (state_q != IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (count_ok) begin
                            accept  = 1'b1;
                            state_d = CALC;
                        end else begin
                            reject  = 1'b1;
                        end
                    end
                end
                CALC:    if (last_word) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Datapath: buffer capture, word folding, result and pulse outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q      <= SEED;
            idx_q      <= '0;
            count_q    <= '0;
            crc_o      <= '0;
            crc_done_o <= 1'b0;
            error_o    <= 1'b0;
            // NOTE: the buffer is a small register file, and it is cleared on reset on purpose so no stale burst data survives.
            for (int k = 0; k < MAX_WORDS; k++) buffer_q[k] <= '0;
        end else begin
            crc_done_o <= (state_q == DONE) && !stop_i;
            error_o    <= reject;

            if (abort) begin
                acc_q <= SEED;
                idx_q <= '0;
            end else if (accept) begin
                for (int k = 0; k < MAX_WORDS; k++) buffer_q[k] <= data_i[k*32 +: 32];
                count_q <= word_count_i;
                acc_q   <= chain_i ? acc_q : SEED;
                idx_q   <= '0;
            end else if (state_q == CALC) begin
                acc_q <= crc32_word(acc_q, buffer_q[idx_q]);
                idx_q <= (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
            end

            if ((state_q == DONE) && !stop_i) crc_o <= ~acc_q;
        end
    end

endmodule
